// File: rtl/alu_pkg.sv
// Shared definitions for the sequential RV32I/M ALU: op codes, the M-select bit, FSM states.
// Op codes are XLEN-independent so that decode logic and benches can share them.
package alu_pkg;

    localparam int OP_M_BIT = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension unit (present only when ALU_MULDIV_EN is defined): one bit per cycle,
// radix-2 shift-add multiply or restoring divide on magnitudes, sign fixed up on the way out.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   mag_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_rem_q;

    logic              a_sgn;
    logic              b_sgn;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        a_sgn = a_i[XLEN-1] && (op_i == MD_MULH || op_i == MD_MULHSU ||
                                op_i == MD_DIV  || op_i == MD_REM);
        b_sgn = b_i[XLEN-1] && (op_i == MD_MULH || op_i == MD_DIV || op_i == MD_REM);
        a_mag = a_sgn ? -a_i : a_i;
        b_mag = b_sgn ? -b_i : b_i;
    end

    // acc_q holds {high product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, mag_q};
        div_ok    = !div_diff[XLEN];
        if (op_q[2]) begin
            acc_d = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ok};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_q ? -acc_d : acc_d;
        if (!op_q[2]) begin
            result_o = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            result_o = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        end else begin
            result_o = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        end
    end

    assign done_o = busy_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            op_q      <= op_i;
            neg_q     <= a_sgn ^ b_sgn;
            neg_rem_q <= a_sgn;
            if (op_i[2]) begin
                acc_q <= {{XLEN{1'b0}}, a_mag};
                mag_q <= b_mag;
            end else begin
                acc_q <= {{XLEN{1'b0}}, b_mag};
                mag_q <= a_mag;
            end
        end else if (busy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked RV32I ALU with registered result; M-extension via alu_muldiv_iter when
// ALU_MULDIV_EN is defined, otherwise M ops return 0 with single-cycle latency.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] d,
    output state_t          dbg_state
);

    localparam int SW = $clog2(XLEN);

    state_t          state_q;
    logic [XLEN-1:0] d_q;

    logic            accept;
    logic            m_iter;
    logic            iter_done;
    logic [XLEN-1:0] iter_res;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] imm_res;
    logic [SW-1:0]   shamt;

    // A finished result leaving this cycle frees the slot for a new request in the same cycle.
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign dbg_state = state_q;
    assign shamt     = s2[SW-1:0];

    always_comb begin
        base_res = '0;
        case (op[3:0])
            ALU_ADD:  base_res = s1 + s2;
            ALU_SUB:  base_res = s1 - s2;
            ALU_SLL:  base_res = s1 << shamt;
            ALU_SRL:  base_res = s1 >> shamt;
            ALU_SRA:  base_res = $signed(s1) >>> shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(s1) < $signed(s2)};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, s1 < s2};
            ALU_XOR:  base_res = s1 ^ s2;
            ALU_OR:   base_res = s1 | s2;
            ALU_AND:  base_res = s1 & s2;
            default:  base_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic            div_zero;
    logic            div_ovf;
    logic            m_special;
    logic [XLEN-1:0] m_special_res;

    // Divide-by-zero and signed overflow bypass the iterative unit with fixed results.
    always_comb begin
        div_zero  = (s2 == '0);
        div_ovf   = !op[0] && (s1 == {1'b1, {(XLEN-1){1'b0}}}) && (s2 == '1);
        m_special = op[2] && (div_zero || div_ovf);
        if (div_zero) begin
            m_special_res = op[1] ? s1 : '1;
        end else begin
            m_special_res = op[1] ? '0 : s1;
        end
    end

    assign m_iter  = op[OP_M_BIT] && !m_special;
    assign imm_res = op[OP_M_BIT] ? m_special_res : base_res;

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept && m_iter),
        .op_i     (op[2:0]),
        .a_i      (s1),
        .b_i      (s2),
        .done_o   (iter_done),
        .result_o (iter_res)
    );
`else
    assign m_iter    = 1'b0;
    assign iter_done = 1'b0;
    assign iter_res  = '0;
    assign imm_res   = op[OP_M_BIT] ? '0 : base_res;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= '0;
        end else if (accept) begin
            if (m_iter) begin
                state_q <= BUSY;
            end else begin
                state_q <= DONE;
                d_q     <= imm_res;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (iter_done) begin
                        state_q <= DONE;
                        d_q     <= iter_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed latency/handshake/corner cases plus randomized ops against
// an arithmetic reference model; follows ALU_MULDIV_EN to pick the expected M behaviour.
module tb_alu_seq;

    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam int ITER_LAT = XLEN + 1;
`else
    localparam int ITER_LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        op = '0;
    logic [XLEN-1:0]   s1 = '0;
    logic [XLEN-1:0]   s2 = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [XLEN-1:0]   d;
    alu_pkg::state_t   dbg_state;

    logic [XLEN-1:0]   exp_q[$];
    logic [XLEN-1:0]   mon_exp;
    int                n_checks = 0;
    int                n_fail = 0;
    int                n_pops = 0;
    int                n_stalls = 0;

    logic [4:0] op_tab [0:19] = '{
        5'b00000, 5'b01000, 5'b00001, 5'b00101, 5'b01101, 5'b00010, 5'b00011,
        5'b00100, 5'b00110, 5'b00111, 5'b01010, 5'b11101,
        5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111
    };

    alu_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .s1        (s1),
        .s2        (s2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0]       sh;
        longint           sa;
        longint           sb;
        longint           ps;
        longint unsigned  ua;
        longint unsigned  ub;
        longint unsigned  pu;
        sh = b[4:0];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (!o[4]) begin
            case (o[3:0])
                4'b0000: return a + b;
                4'b1000: return a - b;
                4'b0001: return a << sh;
                4'b0101: return a >> sh;
                4'b1101: return 32'($signed(a) >>> sh);
                4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
                4'b0011: return (a < b) ? 32'd1 : 32'd0;
                4'b0100: return a ^ b;
                4'b0110: return a | b;
                4'b0111: return a & b;
                default: return 32'd0;
            endcase
        end
`ifdef ALU_MULDIV_EN
        case (o[2:0])
            3'd0: begin pu = ua * ub; return pu[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", d, mon_exp);
                n_pops++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit bp);
        int n = 0;
        in_valid = 1'b1;
        op = o;
        s1 = a;
        s2 = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            if (bp) out_ready = ($urandom_range(0, 3) != 0);
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(o, a, b));
            n_stalls += n;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic timed_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat);
        int lat;
        send(o, a, b, 1'b0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check(tag, lat, exp_lat);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic flush();
        int n = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        int s0;
        int cnt;
        logic [31:0] held;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_d", d, 32'd0);

        timed_op("lat_add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'd1, 1);
        timed_op("lat_sra", 5'b01101, 32'h8000_0000, 32'h21, 1);
        timed_op("lat_invalid_base", 5'b01011, 32'h1234, 32'h5678, 1);

        // four base ops back to back
        p0 = n_pops;
        s0 = n_stalls;
        send(5'b00000, 32'd10, 32'd20, 1'b0);
        send(5'b01000, 32'd3, 32'd5, 1'b0);
        send(5'b00011, 32'd1, 32'hFFFF_FFFF, 1'b0);
        send(5'b00010, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("b2b_no_stall", n_stalls - s0, 32'd0);
        check("b2b_consecutive", n_pops - p0, 32'd3);
        flush();

        // backpressure: result held while consumer stalls
        out_ready = 1'b0;
        send(5'b00100, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        held = model(5'b00100, 32'h1234_5678, 32'h0F0F_0F0F);
        in_valid = 1'b1;
        op = 5'b01000;
        s1 = 32'd5;
        s2 = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_d_stable", d, held);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(5'b01000, 32'd5, 32'd7, 1'b0);
        flush();

        // M-extension corners
        timed_op("lat_mulh", 5'b10001, 32'h8000_0000, 32'h8000_0000, ITER_LAT);
        timed_op("lat_div", 5'b10100, 32'hFFFF_FFF9, 32'd2, ITER_LAT);
        timed_op("lat_rem", 5'b10110, 32'hFFFF_FFF9, 32'd2, ITER_LAT);
        timed_op("lat_divu_zero", 5'b10101, 32'h1234_5678, 32'd0, 1);
        timed_op("lat_rem_zero", 5'b10110, 32'h1234_5678, 32'd0, 1);
        timed_op("lat_div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        timed_op("lat_rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        timed_op("lat_mul_3x4", 5'b10000, 32'd3, 32'd4, ITER_LAT);

        // randomized traffic with random backpressure and idle gaps
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            send(op_tab[$urandom_range(0, 19)], rand_operand(), rand_operand(), 1'b1);
        end
        flush();

        // reset while an op is in flight: nothing may emerge afterwards
        in_valid = 1'b1;
        op = 5'b10000;
        s1 = 32'd3;
        s2 = 32'd4;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef ALU_MULDIV_EN
        repeat (10) @(posedge clk);
        #1;
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_d", d, 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_no_stale", cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
